// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB slave register bank exporting PPC-written words to fabric; OPB bit k is vector bit 31-k.
// Define OPB_REGBANK_SHADOW_EN for shadow registers committed through the 0xFC control word.
module opb_register_bank_ppc2simulink #(
    parameter logic [31:0] C_BASEADDR    = 32'h0108D200,
    parameter logic [31:0] C_HIGHADDR    = 32'h0108D2FF,
    parameter int          C_NUM_REGS    = 8,
    parameter logic [31:0] C_RESET_VALUE = 32'h00000000
) (
    input  logic                       OPB_Clk,
    input  logic                       OPB_Rst_n,
    input  logic [31:0]                OPB_ABus,
    input  logic [3:0]                 OPB_BE,
    input  logic [31:0]                OPB_DBus,
    input  logic                       OPB_RNW,
    input  logic                       OPB_select,
    input  logic                       OPB_seqAddr,
    output logic [31:0]                Sl_DBus,
    output logic                       Sl_xferAck,
    output logic                       Sl_errAck,
    output logic                       Sl_retry,
    output logic                       Sl_toutSup,
    output logic [C_NUM_REGS*32-1:0]   user_data_out,
    output logic [C_NUM_REGS-1:0]      user_update
);

    typedef enum logic [1:0] {IDLE, ACK, WAIT} state_t;
    state_t state, state_nxt;

    logic [31:0] offset;
    logic        hit;
    logic        sel_reg;
    logic        unused;

    assign offset  = OPB_ABus - C_BASEADDR;
    assign hit     = OPB_select && (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);
    assign sel_reg = offset[31:2] < 30'(C_NUM_REGS);
    assign unused  = ^{OPB_seqAddr, offset[1:0]};

    // Decode is captured when the hit is first seen so the ACK cycle
    // does not depend on the master keeping the address stable.
    logic [4:0]  idx_q;
    logic        reg_q;
    logic        rnw_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
`ifdef OPB_REGBANK_SHADOW_EN
    logic        ctrl_q;
`endif

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            idx_q   <= '0;
            reg_q   <= 1'b0;
            rnw_q   <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
`ifdef OPB_REGBANK_SHADOW_EN
            ctrl_q  <= 1'b0;
`endif
        end else if (state == IDLE && hit) begin
            idx_q   <= offset[6:2];
            reg_q   <= sel_reg;
            rnw_q   <= OPB_RNW;
            be_q    <= OPB_BE;
            wdata_q <= OPB_DBus;
`ifdef OPB_REGBANK_SHADOW_EN
            ctrl_q  <= (offset[31:2] == 30'h3F);
`endif
        end
    end

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) state <= IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (hit) state_nxt = ACK;
            ACK:     state_nxt = OPB_select ? WAIT : IDLE;
            WAIT:    if (!OPB_select) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    logic wr_stb;
    assign wr_stb = (state == ACK) && !rnw_q;

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] d,
                                          input logic [3:0]  be);
        logic [31:0] r;
        r = old;
        for (int j = 0; j < 4; j++)
            if (be[j]) r[8*j +: 8] = d[8*j +: 8];
        return r;
    endfunction

    logic [31:0] live [C_NUM_REGS];

`ifdef OPB_REGBANK_SHADOW_EN
    logic [31:0] shadow [C_NUM_REGS];
    logic        pending;
    logic        commit;

    assign commit = wr_stb && ctrl_q && be_q[0] && wdata_q[0];

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            pending     <= 1'b0;
            user_update <= '0;
            for (int i = 0; i < C_NUM_REGS; i++) begin
                live[i]   <= C_RESET_VALUE;
                shadow[i] <= C_RESET_VALUE;
            end
        end else begin
            user_update <= '0;
            if (wr_stb && reg_q) pending <= 1'b1;
            if (commit)          pending <= 1'b0;
            for (int i = 0; i < C_NUM_REGS; i++) begin
                if (wr_stb && reg_q && idx_q == 5'(i))
                    shadow[i] <= merge(shadow[i], wdata_q, be_q);
                if (commit) begin
                    live[i]        <= shadow[i];
                    user_update[i] <= 1'b1;
                end
            end
        end
    end
`else
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            user_update <= '0;
            for (int i = 0; i < C_NUM_REGS; i++)
                live[i] <= C_RESET_VALUE;
        end else begin
            user_update <= '0;
            for (int i = 0; i < C_NUM_REGS; i++) begin
                if (wr_stb && reg_q && idx_q == 5'(i)) begin
                    live[i]        <= merge(live[i], wdata_q, be_q);
                    user_update[i] <= 1'b1;
                end
            end
        end
    end
`endif

    logic [31:0] rdata;

    always_comb begin
        rdata = '0;
        for (int i = 0; i < C_NUM_REGS; i++) begin
            if (reg_q && idx_q == 5'(i)) begin
`ifdef OPB_REGBANK_SHADOW_EN
                rdata = shadow[i];
`else
                rdata = live[i];
`endif
            end
        end
`ifdef OPB_REGBANK_SHADOW_EN
        if (ctrl_q) rdata = {31'b0, pending};
`endif
    end

    always_comb begin
        user_data_out = '0;
        for (int i = 0; i < C_NUM_REGS; i++)
            user_data_out[32*i +: 32] = live[i];
    end

    assign Sl_xferAck = (state == ACK);
    assign Sl_DBus    = (state == ACK && rnw_q) ? rdata : '0;
    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Directed and random OPB transfers checked against an array model of the bank.
module tb_opb_register_bank_ppc2simulink;

    localparam logic [31:0] BASE = 32'h0108D200;
    localparam logic [31:0] HIGH = 32'h0108D2FF;
    localparam int          NREG = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic [31:0] abus, dbus;
    logic [3:0]  be;
    logic rnw, sel, seq;
    logic [31:0] sl_dbus;
    logic ack, err_ack, retry, tout;
    logic [NREG*32-1:0] udo;
    logic [NREG-1:0]    upd;

    int errors = 0;
    int checks = 0;

    logic [31:0] live_m [NREG];
    logic [31:0] shad_m [NREG];
    logic        pend_m;

    always #5 clk = ~clk;

    opb_register_bank_ppc2simulink dut (
        .OPB_Clk(clk), .OPB_Rst_n(rst_n), .OPB_ABus(abus), .OPB_BE(be),
        .OPB_DBus(dbus), .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq),
        .Sl_DBus(sl_dbus), .Sl_xferAck(ack), .Sl_errAck(err_ack),
        .Sl_retry(retry), .Sl_toutSup(tout),
        .user_data_out(udo), .user_update(upd)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lanes(input logic [3:0] b);
        logic [31:0] m;
        m = '0;
        for (int j = 0; j < 4; j++)
            if (b[j]) m = m | (32'hFF << (8 * j));
        return m;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) begin
            live_m[i] = '0;
            shad_m[i] = '0;
        end
        pend_m = 1'b0;
    endtask

    task automatic chk_live(input string tag);
        for (int i = 0; i < NREG; i++)
            chk($sformatf("%s.udo%0d", tag, i), udo[32*i +: 32], live_m[i]);
    endtask

    int          x_acks, x_lat, x_updcyc;
    logic [31:0] x_rd;
    logic [NREG-1:0] x_upd;
    logic        x_dbus_bad;

    task automatic xfer(input logic [31:0] a, input logic r, input logic [31:0] d,
                        input logic [3:0] b, input int hold, input logic s);
        @(negedge clk);
        abus = a; rnw = r; dbus = d; be = b; sel = s;
        x_acks = 0; x_lat = -1; x_updcyc = 0; x_rd = '0; x_upd = '0; x_dbus_bad = 1'b0;
        for (int c = 1; c <= hold + 2; c++) begin
            @(negedge clk);
            if (ack) begin
                x_acks++;
                if (x_lat < 0) x_lat = c;
                x_rd = sl_dbus;
            end else if (sl_dbus !== 32'h0) begin
                x_dbus_bad = 1'b1;
            end
            if (upd !== '0) begin
                x_updcyc++;
                x_upd = x_upd | upd;
            end
            if (c == hold) sel = 1'b0;
        end
    endtask

    task automatic txn(input string tag, input logic [31:0] a, input logic r,
                       input logic [31:0] d, input logic [3:0] b, input int hold,
                       input logic s);
        logic in_rng, is_reg, is_ctl;
        int   idx;
        logic [31:0] exp_rd, m;
        logic [NREG-1:0] exp_upd;
        in_rng  = s && (a >= BASE) && (a <= HIGH);
        idx     = in_rng ? int'((a - BASE) >> 2) : 0;
        is_reg  = in_rng && idx < NREG;
        is_ctl  = in_rng && idx == 63;
        exp_rd  = '0;
        exp_upd = '0;
        m       = lanes(b);
        xfer(a, r, d, b, hold, s);
        if (in_rng && r) begin
`ifdef OPB_REGBANK_SHADOW_EN
            if (is_reg) exp_rd = shad_m[idx];
            if (is_ctl) exp_rd = {31'b0, pend_m};
`else
            if (is_reg) exp_rd = live_m[idx];
`endif
        end
        if (in_rng && !r) begin
`ifdef OPB_REGBANK_SHADOW_EN
            if (is_reg) begin
                shad_m[idx] = (shad_m[idx] & ~m) | (d & m);
                pend_m = 1'b1;
            end
            if (is_ctl && b[0] && d[0]) begin
                for (int i = 0; i < NREG; i++) live_m[i] = shad_m[i];
                exp_upd = '1;
                pend_m  = 1'b0;
            end
`else
            if (is_reg) begin
                live_m[idx] = (live_m[idx] & ~m) | (d & m);
                exp_upd[idx] = 1'b1;
            end
`endif
        end
        chk({tag, ".acks"}, 32'(x_acks), in_rng ? 32'd1 : 32'd0);
        if (in_rng) chk({tag, ".lat"}, 32'(x_lat), 32'd1);
        chk({tag, ".rd"}, x_rd, exp_rd);
        chk({tag, ".dbus_idle"}, 32'(x_dbus_bad), 32'd0);
        chk({tag, ".upd"}, 32'(x_upd), 32'(exp_upd));
        chk({tag, ".updcyc"}, 32'(x_updcyc), (exp_upd != '0) ? 32'd1 : 32'd0);
        chk_live(tag);
    endtask

    initial begin
        rst_n = 1'b0; sel = 1'b0; rnw = 1'b0; seq = 1'b0;
        abus = '0; dbus = '0; be = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst.ack", 32'(ack), 32'd0);
        chk("rst.dbus", sl_dbus, 32'h0);
        chk("rst.upd", 32'(upd), 32'd0);
        chk("rst.const", 32'({err_ack, retry, tout}), 32'd0);
        chk_live("rst");
        rst_n = 1'b1;

        txn("w_deadbeef", BASE + 32'h08, 1'b0, 32'hDEADBEEF, 4'b1111, 2, 1'b1);
`ifndef OPB_REGBANK_SHADOW_EN
        chk("w_deadbeef.word", udo[95:64], 32'hDEADBEEF);
        chk("w_deadbeef.updv", 32'(x_upd), 32'h04);
`endif
        txn("w_be0100", BASE, 1'b0, 32'h11223344, 4'b0100, 2, 1'b1);
        txn("r_be0100", BASE, 1'b1, 32'h0, 4'b1111, 2, 1'b1);
        chk("r_be0100.val", x_rd, 32'h00220000);

        txn("w_reg3", BASE + 32'h0C, 1'b0, 32'hCAFE0003, 4'b1111, 2, 1'b1);
        txn("r_hold5", BASE + 32'h0C, 1'b1, 32'h0, 4'b1111, 5, 1'b1);
        chk("r_hold5.val", x_rd, 32'hCAFE0003);

        txn("w_rsvd", BASE + 32'h40, 1'b0, 32'h12345678, 4'b1111, 2, 1'b1);
        txn("r_rsvd", BASE + 32'h40, 1'b1, 32'h0, 4'b1111, 2, 1'b1);
        txn("w_drop_in_ack", BASE + 32'h14, 1'b0, 32'h0BADF00D, 4'b1111, 1, 1'b1);
        txn("r_after_drop", BASE + 32'h14, 1'b1, 32'h0, 4'b1111, 2, 1'b1);
        txn("w_out_rng", HIGH + 32'h1, 1'b0, 32'hFFFFFFFF, 4'b1111, 3, 1'b1);
        txn("w_below", BASE - 32'h4, 1'b0, 32'hFFFFFFFF, 4'b1111, 3, 1'b1);
        txn("w_no_sel", BASE + 32'h04, 1'b0, 32'hFFFFFFFF, 4'b1111, 3, 1'b0);

        @(negedge clk);
        abus = BASE + 32'h10; rnw = 1'b0; dbus = 32'hA5A5A5A5; be = 4'b1111; sel = 1'b1;
        @(negedge clk);
        chk("rst_mid.ack_before", 32'(ack), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid.ack_drop", 32'(ack), 32'd0);
        chk("rst_mid.dbus", sl_dbus, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        sel = 1'b0;
        model_reset();
        chk_live("rst_mid");
        txn("rst_mid.rd", BASE + 32'h10, 1'b1, 32'h0, 4'b1111, 2, 1'b1);
        chk("rst_mid.val", x_rd, 32'h0);

        for (int n = 0; n < 30; n++) begin
            logic [31:0] a;
            int k;
            k = int'($urandom_range(0, 10));
            if (k < 8)       a = BASE + 32'(4 * k);
            else if (k == 8) a = BASE + 32'(4 * $urandom_range(8, 62));
            else if (k == 9) a = BASE + 32'hFC;
            else             a = HIGH + 32'(4 * $urandom_range(1, 8));
            txn($sformatf("rnd%0d", n), a, 1'($urandom_range(0, 1)), $urandom,
                4'($urandom_range(0, 15)), int'($urandom_range(1, 4)), 1'b1);
        end

`ifdef OPB_REGBANK_SHADOW_EN
        txn("sh.commit0", BASE + 32'hFC, 1'b0, 32'h1, 4'b1111, 2, 1'b1);
        txn("sh.w1", BASE + 32'h04, 1'b0, 32'h5, 4'b1111, 2, 1'b1);
        txn("sh.rpend", BASE + 32'hFC, 1'b1, 32'h0, 4'b1111, 2, 1'b1);
        chk("sh.pend1", x_rd, 32'h1);
        txn("sh.commit", BASE + 32'hFC, 1'b0, 32'h1, 4'b1111, 2, 1'b1);
        chk("sh.live1", udo[63:32], 32'h5);
        chk("sh.updall", 32'(x_upd), 32'hFF);
        txn("sh.rpend0", BASE + 32'hFC, 1'b1, 32'h0, 4'b1111, 2, 1'b1);
        chk("sh.pend0", x_rd, 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
